// File: rtl/hours_counter_bcd.sv
// BCD hour counter for the two hour digits: 24h or 12h (AM/PM) format, manual set,
// direct load, set-mode blink on RPH and a day-rollover pulse.
module hours_counter_bcd #(
   parameter int unsigned MODE_12     = 0,
   parameter int unsigned SYNC_STAGES = 1,
   parameter int unsigned BLINK_DIV   = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       set_en,
   input  logic       set_inc,
   input  logic       load_en,
   input  logic [3:0] load_lh,
   input  logic [3:0] load_rh,
   input  logic       load_pm,
   output logic [3:0] RH,
   output logic       RPH,
   output logic [3:0] LH,
   output logic       LPH,
   output logic       day_tick,
   output logic       load_err
);

   localparam bit          Is12 = (MODE_12 != 0);
   localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);
   localparam logic [3:0]  RstLh = Is12 ? 4'd1 : 4'd0;
   localparam logic [3:0]  RstRh = Is12 ? 4'd2 : 4'd0;

   logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
   logic [SYNC_STAGES-1:0] inc_sync_q, inc_sync_d;
   logic                   tick_prev_q, inc_prev_q;
   logic                   tick_edge, inc_edge, adv, tick_adv;

   logic [3:0]      lh_q, lh_d, rh_q, rh_d;
   logic            pm_q, pm_d, day_q, day_d, err_q, err_d;
   logic            rph_q, set_prev_q;
   logic [CntW-1:0] cnt_q;
   logic            load_bcd, load_ok;

   if (SYNC_STAGES > 1) begin : g_chain
      assign tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], tick_in};
      assign inc_sync_d  = {inc_sync_q[SYNC_STAGES-2:0], set_inc};
   end else begin : g_single
      assign tick_sync_d = tick_in;
      assign inc_sync_d  = set_inc;
   end

   assign tick_edge = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
   assign inc_edge  = inc_sync_q[SYNC_STAGES-1] & ~inc_prev_q;
   // Ticks arriving in set mode are dropped; set_inc is only honoured in set mode.
   assign tick_adv  = tick_edge & ~set_en;
   assign adv       = set_en ? inc_edge : tick_edge;

   always_comb begin
      load_bcd = (load_lh <= 4'd9) && (load_rh <= 4'd9);
      if (Is12) begin
         load_ok = load_bcd && (((load_lh == 4'd0) && (load_rh != 4'd0)) ||
                                ((load_lh == 4'd1) && (load_rh <= 4'd2)));
      end else begin
         load_ok = load_bcd && ((load_lh <= 4'd1) ||
                                ((load_lh == 4'd2) && (load_rh <= 4'd3)));
      end
   end

   always_comb begin
      lh_d  = lh_q;
      rh_d  = rh_q;
      pm_d  = pm_q;
      day_d = 1'b0;
      err_d = 1'b0;
      if (load_en) begin
         if (load_ok) begin
            lh_d = load_lh;
            rh_d = load_rh;
            pm_d = Is12 ? load_pm : 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else if (adv) begin
         if (Is12) begin
            if ((lh_q == 4'd1) && (rh_q == 4'd2)) begin
               lh_d = 4'd0;
               rh_d = 4'd1;
            end else if ((lh_q == 4'd1) && (rh_q == 4'd1)) begin
               lh_d  = 4'd1;
               rh_d  = 4'd2;
               pm_d  = ~pm_q;
               day_d = tick_adv & pm_q;
            end else if (rh_q == 4'd9) begin
               lh_d = lh_q + 4'd1;
               rh_d = 4'd0;
            end else begin
               rh_d = rh_q + 4'd1;
            end
         end else begin
            if ((lh_q == 4'd2) && (rh_q == 4'd3)) begin
               lh_d  = 4'd0;
               rh_d  = 4'd0;
               day_d = tick_adv;
            end else if (rh_q == 4'd9) begin
               lh_d = lh_q + 4'd1;
               rh_d = 4'd0;
            end else begin
               rh_d = rh_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_sync_q <= '0;
         inc_sync_q  <= '0;
         tick_prev_q <= 1'b0;
         inc_prev_q  <= 1'b0;
         lh_q        <= RstLh;
         rh_q        <= RstRh;
         pm_q        <= 1'b0;
         day_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         tick_sync_q <= tick_sync_d;
         inc_sync_q  <= inc_sync_d;
         tick_prev_q <= tick_sync_q[SYNC_STAGES-1];
         inc_prev_q  <= inc_sync_q[SYNC_STAGES-1];
         lh_q        <= lh_d;
         rh_q        <= rh_d;
         pm_q        <= pm_d;
         day_q       <= day_d;
         err_q       <= err_d;
      end
   end

   // Blink: first set-mode cycle forces RPH high, then toggles every BLINK_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst || !set_en) begin
         rph_q      <= 1'b0;
         cnt_q      <= '0;
         set_prev_q <= 1'b0;
      end else begin
         set_prev_q <= 1'b1;
         if (!set_prev_q) begin
            rph_q <= 1'b1;
            cnt_q <= '0;
         end else if (cnt_q == CntMax) begin
            rph_q <= ~rph_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign LH       = lh_q;
   assign RH       = rh_q;
   assign LPH      = pm_q;
   assign RPH      = rph_q;
   assign day_tick = day_q;
   assign load_err = err_q;

endmodule

// File: tb/tb_hours_counter_bcd.sv
// Directed bench for hours_counter_bcd: a 24h and a 12h instance share one stimulus set.
module tb_hours_counter_bcd;

   logic       clk = 1'b0;
   logic       rst, tick_in, set_en, set_inc, load_en, load_pm;
   logic [3:0] load_lh, load_rh;

   logic [3:0] a_lh, a_rh, b_lh, b_rh;
   logic       a_lph, a_rph, a_day, a_err, b_lph, b_rph, b_day, b_err;

   int checks = 0;
   int errors = 0;
   int day_a  = 0;
   int day_b  = 0;

   always #5 clk = ~clk;

   hours_counter_bcd #(.MODE_12(0), .SYNC_STAGES(1), .BLINK_DIV(4)) dut24 (
      .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en), .set_inc(set_inc),
      .load_en(load_en), .load_lh(load_lh), .load_rh(load_rh), .load_pm(load_pm),
      .RH(a_rh), .RPH(a_rph), .LH(a_lh), .LPH(a_lph), .day_tick(a_day), .load_err(a_err)
   );

   hours_counter_bcd #(.MODE_12(1), .SYNC_STAGES(1), .BLINK_DIV(4)) dut12 (
      .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en), .set_inc(set_inc),
      .load_en(load_en), .load_lh(load_lh), .load_rh(load_rh), .load_pm(load_pm),
      .RH(b_rh), .RPH(b_rph), .LH(b_lh), .LPH(b_lph), .day_tick(b_day), .load_err(b_err)
   );

   typedef struct {
      logic [3:0] lh, rh;
      logic       pm;
      logic [3:0] e24_lh, e24_rh;
      logic       e24_err;
      logic [3:0] e12_lh, e12_rh;
      logic       e12_pm, e12_err;
   } load_vec_t;

   load_vec_t vecs[10];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (a_day) day_a++;
      if (b_day) day_b++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic do_tick();
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
      step();
      step();
   endtask

   task automatic do_load(input logic [3:0] lh, input logic [3:0] rh, input logic pm);
      load_en = 1'b1;
      load_lh = lh;
      load_rh = rh;
      load_pm = pm;
      step();
      load_en = 1'b0;
   endtask

   initial begin
      int h;
      int d0;
      rst = 1'b1; tick_in = 1'b0; set_en = 1'b0; set_inc = 1'b0;
      load_en = 1'b0; load_lh = 4'd0; load_rh = 4'd0; load_pm = 1'b0;

      vecs[0] = '{4'd2, 4'd4,  1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b1};
      vecs[1] = '{4'd1, 4'd9,  1'b0, 4'd1, 4'd9, 1'b0, 4'd1, 4'd2, 1'b0, 1'b1};
      vecs[2] = '{4'd1, 4'd2,  1'b1, 4'd1, 4'd2, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0};
      vecs[3] = '{4'd0, 4'd0,  1'b0, 4'd0, 4'd0, 1'b0, 4'd1, 4'd2, 1'b1, 1'b1};
      vecs[4] = '{4'd2, 4'd3,  1'b1, 4'd2, 4'd3, 1'b0, 4'd1, 4'd2, 1'b1, 1'b1};
      vecs[5] = '{4'd0, 4'd10, 1'b0, 4'd2, 4'd3, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1};
      vecs[6] = '{4'd0, 4'd7,  1'b0, 4'd0, 4'd7, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0};
      vecs[7] = '{4'd1, 4'd0,  1'b1, 4'd1, 4'd0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
      vecs[8] = '{4'd3, 4'd0,  1'b0, 4'd1, 4'd0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b1};
      vecs[9] = '{4'd1, 4'd3,  1'b0, 4'd1, 4'd3, 1'b0, 4'd1, 4'd0, 1'b1, 1'b1};

      // Reset state
      step();
      do_reset();
      chk("rst24_lh", a_lh, 0);
      chk("rst24_rh", a_rh, 0);
      chk("rst24_lph", a_lph, 0);
      chk("rst24_rph", a_rph, 0);
      chk("rst24_day", a_day, 0);
      chk("rst24_err", a_err, 0);
      chk("rst12_lh", b_lh, 1);
      chk("rst12_rh", b_rh, 2);
      chk("rst12_lph", b_lph, 0);

      // 24 ticks through a full day, checking the two-cycle latency
      day_a = 0;
      for (int i = 1; i <= 24; i++) begin
         h = (i - 1) % 24;
         tick_in = 1'b1;
         step();
         chk("t24_hold", a_lh * 10 + a_rh, h);
         tick_in = 1'b0;
         step();
         h = i % 24;
         chk("t24_lh", a_lh, h / 10);
         chk("t24_rh", a_rh, h % 10);
         chk("t24_day", a_day, (i == 24) ? 1 : 0);
         step();
         chk("t24_day_off", a_day, 0);
      end
      chk("t24_day_cnt", day_a, 1);

      // 12h sequence
      do_reset();
      day_b = 0;
      do_tick();
      chk("t12_01", b_lh * 10 + b_rh, 1);
      for (int i = 2; i <= 10; i++) do_tick();
      chk("t12_10", b_lh * 10 + b_rh, 10);
      do_tick();
      chk("t12_11", b_lh * 10 + b_rh, 11);
      chk("t12_11_pm", b_lph, 0);
      do_tick();
      chk("t12_12pm", b_lh * 10 + b_rh, 12);
      chk("t12_12pm_pm", b_lph, 1);
      chk("t12_noon_day", day_b, 0);
      do_tick();
      chk("t12_01pm", b_lh * 10 + b_rh, 1);
      chk("t12_01pm_pm", b_lph, 1);
      for (int i = 14; i <= 24; i++) do_tick();
      chk("t12_12am", b_lh * 10 + b_rh, 12);
      chk("t12_12am_pm", b_lph, 0);
      chk("t12_day_cnt", day_b, 1);

      // tick held high for 100 cycles counts once
      do_reset();
      tick_in = 1'b1;
      for (int i = 0; i < 100; i++) step();
      tick_in = 1'b0;
      step();
      step();
      chk("held_once", a_lh * 10 + a_rh, 1);

      // ticks in set mode are dropped
      set_en = 1'b1;
      for (int i = 0; i < 3; i++) do_tick();
      chk("set_drop", a_lh * 10 + a_rh, 1);
      set_en = 1'b0;
      step();
      step();
      chk("set_drop_after", a_lh * 10 + a_rh, 1);

      // set_inc ignored outside set mode
      set_inc = 1'b1; step(); set_inc = 1'b0; step(); step();
      chk("inc_ignored", a_lh * 10 + a_rh, 1);

      // set_inc from 23 wraps without day_tick
      do_load(4'd2, 4'd3, 1'b0);
      chk("ld23", a_lh * 10 + a_rh, 23);
      d0 = day_a;
      set_en = 1'b1;
      set_inc = 1'b1;
      step();
      set_inc = 1'b0;
      step();
      chk("inc_wrap", a_lh * 10 + a_rh, 0);
      chk("inc_wrap_day", a_day, 0);
      step();
      chk("inc_day_cnt", day_a - d0, 0);
      set_en = 1'b0;
      step();

      // Table-driven loads against both formats
      do_reset();
      for (int i = 0; i < 10; i++) begin
         do_load(vecs[i].lh, vecs[i].rh, vecs[i].pm);
         chk($sformatf("ld%0d_24", i), a_lh * 10 + a_rh, vecs[i].e24_lh * 10 + vecs[i].e24_rh);
         chk($sformatf("ld%0d_24lph", i), a_lph, 0);
         chk($sformatf("ld%0d_24err", i), a_err, vecs[i].e24_err);
         chk($sformatf("ld%0d_12", i), b_lh * 10 + b_rh, vecs[i].e12_lh * 10 + vecs[i].e12_rh);
         chk($sformatf("ld%0d_12pm", i), b_lph, vecs[i].e12_pm);
         chk($sformatf("ld%0d_12err", i), b_err, vecs[i].e12_err);
         step();
         chk($sformatf("ld%0d_err_off", i), a_err | b_err, 0);
      end

      // load coincident with a synced tick edge: load wins, no extra advance
      tick_in = 1'b1;
      step();
      do_load(4'd0, 4'd5, 1'b0);
      chk("ld_vs_tick", a_lh * 10 + a_rh, 5);
      tick_in = 1'b0;
      step();
      step();
      chk("ld_vs_tick_after", a_lh * 10 + a_rh, 5);

      // Blink with BLINK_DIV=4
      chk("rph_idle", a_rph, 0);
      set_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("rph_k%0d", k), a_rph, (((k - 1) / 4) % 2 == 0) ? 1 : 0);
      end
      set_en = 1'b0;
      step();
      chk("rph_drop", a_rph, 0);

      // reset mid-sequence at 17 in set mode
      do_load(4'd1, 4'd7, 1'b0);
      chk("ld17", a_lh * 10 + a_rh, 17);
      set_en = 1'b1;
      step();
      step();
      chk("rph_pre_rst", a_rph, 1);
      rst = 1'b1;
      step();
      chk("rst_mid_digits", a_lh * 10 + a_rh, 0);
      chk("rst_mid_rph", a_rph, 0);
      chk("rst_mid_12", b_lh * 10 + b_rh, 12);
      rst = 1'b0;
      set_en = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hours_counter_bcd.md
Name: hours_counter_bcd

Overview:
Parametrised BCD hour counter driving the two hour digits and their decimal points on the clock display. It advances on a one-hour tick from the minutes stage and supports 24-hour or 12-hour (AM/PM) format, manual set, and direct load. It raises a day-rollover pulse for downstream date logic. It sits between the minutes counter and the hour-digit segment decoders.

Parameters:
MODE_12, 0, 0 selects 24-hour format (00-23); 1 selects 12-hour format (12,01-11 with PM flag).
SYNC_STAGES, 1, number of input register stages on tick_in and set_inc before edge detection (range 1-3).
BLINK_DIV, 50000000, clk cycles per half-period of the set-mode blink on RPH (must be >= 2).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
tick_in  in  1  hour-advance request from minutes rollover (level or pulse; rising edge counts)
set_en  in  1  set mode enable; high = manual adjust
set_inc  in  1  manual increment request (rising edge counts, honoured only when set_en=1)
load_en  in  1  single-cycle direct load strobe
load_lh  in  4  BCD tens digit to load
load_rh  in  4  BCD units digit to load
load_pm  in  1  PM flag to load (ignored when MODE_12=0)
RH  out  4  hour units digit, BCD
RPH  out  1  units decimal point: set-mode blink
LH  out  4  hour tens digit, BCD (0-2)
LPH  out  1  tens decimal point: PM indicator (always 0 when MODE_12=0)
day_tick  out  1  one-cycle pulse on midnight rollover
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (rst=1 at clock edge): MODE_12=0 -> LH=0,RH=0; MODE_12=1 -> LH=1,RH=2 (12 AM); LPH=0, RPH=0, day_tick=0, load_err=0; sync chains, edge-detect registers and blink counter cleared. rst overrides all other inputs.
- Input path: tick_in and set_inc each pass through SYNC_STAGES flops, then rising-edge detect against one more flop. A held-high input counts once. Latency from input rise to digit update = SYNC_STAGES+1 cycles.
- Advance event: the counter advances on an edge of tick_in when set_en=0, or on an edge of set_inc when set_en=1.
  - Edges of tick_in while set_en=1 are dropped, not queued.
  - Edges of set_inc while set_en=0 are ignored.
- 24h sequence: units wrap 9->0 with tens+1; 23->00 asserts day_tick for one cycle, coincident with the digit update.
- 12h sequence: 12->01; 09->10; 11->12 toggles PM; 12 AM follows 11 PM.
  - day_tick fires on the 11 PM -> 12 AM transition only.
- day_tick is never asserted for advances caused by set_inc or by load.
- Load: load_en sampled directly, no sync stages; digits update on the next edge.
  - Valid in 24h: value 00-23.
  - Valid in 12h: value 01-12; PM takes load_pm.
  - Invalid values (non-BCD digit, out of range) leave the state unchanged and pulse load_err for one cycle.
- Priority per cycle: rst > load_en > advance event. An advance event coincident with load_en is discarded.
- RPH: 0 while set_en=0. While set_en=1, a counter counts to BLINK_DIV-1 and then toggles RPH; RPH starts at 1 on the cycle after set_en rises. Deasserting set_en clears RPH and the counter on the next edge.
- Outputs: all outputs are registered, and every case is fully specified, so no latches are produced.
- Digits are always valid BCD within range; no illegal state is reachable from reset.

Test Plan:
- Reset then 24 tick_in pulses (MODE_12=0, SYNC_STAGES=1) -> digits step 00,01..23,00; each update 2 cycles after the tick edge; day_tick is a single cycle only at 23->00.
- MODE_12=1: reset -> 12, LPH=0. Then 11 ticks -> 11 AM; 1 tick -> 12, LPH=1; 12 more ticks -> 12 AM, LPH=0, with exactly one day_tick.
- tick_in held high 100 cycles -> exactly one advance.
- set_en=1 with tick_in edges -> no change.
- set_en=1 with set_inc edges from 23 -> 00 and day_tick stays 0.
- Load 2/4 in 24h -> load_err pulse, digits unchanged.
- Load 1/9 -> 19.
- load_en coincident with a synced tick edge -> loaded value wins, no extra advance.
- BLINK_DIV=4, set_en=1 for 20 cycles -> RPH toggles every 4 cycles starting at 1.
- Drop set_en -> RPH=0 next cycle.
- Apply rst mid-sequence at 17 with set_en=1 -> next cycle 00, RPH=0.
